// File: rtl/calc_pkg.sv
// Shared calculator definitions: widths, opcodes, controller states.
// Imported by the ALU, the interfaces and the register-file controller.
package calc_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_RD  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_RESP
  } state_e;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Request/response bundle and register-file port bundle.
// master drives requests (calc_if) or addresses (rf_if).
interface calc_if
  import calc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_rd;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;
  logic [DATA_W-1:0] req_imm;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_zero;
  logic              resp_ovf;
  logic              resp_err;

  modport master (
    output req_valid, req_op, req_rd,
    output req_rs1, req_rs2, req_imm,
    output resp_ready,
    input  req_ready, resp_valid, resp_data,
    input  resp_zero, resp_ovf, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_rd,
    input  req_rs1, req_rs2, req_imm,
    input  resp_ready,
    output req_ready, resp_valid, resp_data,
    output resp_zero, resp_ovf, resp_err
  );
endinterface

interface rf_if
  import calc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic [ADDR_W-1:0] rf_read_reg1;
  logic [ADDR_W-1:0] rf_read_reg2;
  logic [DATA_W-1:0] rf_read_data1;
  logic [DATA_W-1:0] rf_read_data2;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_write;

  modport master (
    output rf_read_reg1, rf_read_reg2,
    output rf_write_reg, rf_write_data, rf_write,
    input  rf_read_data1, rf_read_data2
  );

  modport slave (
    input  rf_read_reg1, rf_read_reg2,
    input  rf_write_reg, rf_write_data, rf_write,
    output rf_read_data1, rf_read_data2
  );
endinterface

// File: rtl/calc_alu.sv
// Combinational calculator ALU: wraparound arithmetic,
// zero flag and signed overflow for ADD/SUB.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] res_o,
  output logic              zero_o,
  output logic              ovf_o,
  output logic              err_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] dif;
  logic              lt;

  assign sum = a_i + b_i;
  assign dif = a_i - b_i;
  assign lt  = $signed(a_i) < $signed(b_i);

  always_comb begin
    res_o = '0;
    ovf_o = 1'b0;
    err_o = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        res_o = sum;
        ovf_o = (a_i[MSB] == b_i[MSB]) &&
                (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        res_o = dif;
        ovf_o = (a_i[MSB] != b_i[MSB]) &&
                (dif[MSB] != a_i[MSB]);
      end
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_SLT: res_o = {{(DATA_W-1){1'b0}}, lt};
      OP_LDI: res_o = imm_i;
      OP_RD:  res_o = a_i;
      // only reachable with an undefined opcode
      default: err_o = 1'b1;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: read, execute, write back, respond.
// Read addresses move to rd^1 during WRITE so the write always commits.
module regfile_access_ctrl
  import calc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic   clk,
  input logic   rst_n,
  calc_if.slave req,
  rf_if.master  rf
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_zero_q, resp_zero_d;
  logic              resp_ovf_q, resp_ovf_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-1:0] rr1_q, rr1_d;
  logic [ADDR_W-1:0] rr2_q, rr2_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_ovf;
  logic              alu_err;

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i   (op_q),
    .a_i    (rf.rf_read_data1),
    .b_i    (rf.rf_read_data2),
    .imm_i  (imm_q),
    .res_o  (alu_res),
    .zero_o (alu_zero),
    .ovf_o  (alu_ovf),
    .err_o  (alu_err)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    imm_d        = imm_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    resp_ovf_d   = resp_ovf_q;
    resp_err_d   = resp_err_q;
    rr1_d        = rr1_q;
    rr2_d        = rr2_q;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (req.req_valid) begin
          op_d        = req.req_op;
          rd_d        = req.req_rd;
          imm_d       = req.req_imm;
          rr1_d       = req.req_rs1;
          rr2_d       = req.req_rs2;
          req_ready_d = 1'b0;
          state_d     = S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        resp_data_d = alu_res;
        resp_zero_d = alu_zero;
        resp_ovf_d  = alu_ovf;
        resp_err_d  = alu_err;
        rr1_d       = {rd_q[ADDR_W-1:1], ~rd_q[0]};
        rr2_d       = {rd_q[ADDR_W-1:1], ~rd_q[0]};
        wreg_d      = rd_q;
        wdata_d     = alu_res;
        wr_d        = !alu_err && (op_q != OP_RD);
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        wr_d         = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (req.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        wr_d         = 1'b0;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      resp_ovf_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      rr1_q        <= '0;
      rr2_q        <= '0;
      wreg_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      imm_q        <= imm_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
      resp_ovf_q   <= resp_ovf_d;
      resp_err_q   <= resp_err_d;
      rr1_q        <= rr1_d;
      rr2_q        <= rr2_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
    end
  end

  assign req.req_ready     = req_ready_q;
  assign req.resp_valid    = resp_valid_q;
  assign req.resp_data     = resp_data_q;
  assign req.resp_zero     = resp_zero_q;
  assign req.resp_ovf      = resp_ovf_q;
  assign req.resp_err      = resp_err_q;
  assign rf.rf_read_reg1   = rr1_q;
  assign rf.rf_read_reg2   = rr2_q;
  assign rf.rf_write_reg   = wreg_q;
  assign rf.rf_write_data  = wdata_q;
  assign rf.rf_write       = wr_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench with a register-file model and a response scoreboard.
// The model drops colliding writes exactly as the real register file does.
module tb_regfile_access_ctrl;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_if #(.DATA_W(32), .ADDR_W(5)) c ();
  rf_if   #(.DATA_W(32), .ADDR_W(5)) r ();

  regfile_access_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (c.slave),
    .rf    (r.master)
  );

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        o;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] regs[32];
  int          drops = 0;
  int          wr_pulses = 0;
  logic [4:0]  wr_reg_s, rr1_s, rr2_s;
  logic [31:0] wr_data_s;

  initial for (int i = 0; i < 32; i++) regs[i] = '0;

  always @(posedge clk) begin
    r.rf_read_data1 <= regs[r.rf_read_reg1];
    r.rf_read_data2 <= regs[r.rf_read_reg2];
    if (r.rf_write === 1'b1) begin
      if (r.rf_write_reg == r.rf_read_reg1 ||
          r.rf_write_reg == r.rf_read_reg2)
        drops <= drops + 1;
      else
        regs[r.rf_write_reg] <= r.rf_write_data;
    end
  end

  always @(negedge clk) begin
    if (r.rf_write === 1'b1) begin
      wr_pulses++;
      wr_reg_s  = r.rf_write_reg;
      wr_data_s = r.rf_write_data;
      rr1_s     = r.rf_read_reg1;
      rr2_s     = r.rf_read_reg2;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op,
                      input logic [4:0] rd,
                      input logic [4:0] rs1,
                      input logic [4:0] rs2,
                      input logic [31:0] imm);
    int n = 0;
    while (c.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", {31'b0, c.req_ready}, 32'd1);
    wr_pulses   = 0;
    c.req_valid = 1'b1;
    c.req_op    = op;
    c.req_rd    = rd;
    c.req_rs1   = rs1;
    c.req_rs2   = rs2;
    c.req_imm   = imm;
    @(posedge clk); #1;
    c.req_valid = 1'b0;
  endtask

  task automatic recv(input string tag,
                      input int exp_wr,
                      input logic [4:0] exp_wreg,
                      input int stall);
    exp_t e;
    int n = 0;
    while (c.resp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, n, 32'd3);
    chk({tag, "_sb"}, {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, c.resp_data, e.d);
      chk({tag, "_zero"}, {31'b0, c.resp_zero}, {31'b0, e.z});
      chk({tag, "_ovf"}, {31'b0, c.resp_ovf}, {31'b0, e.o});
      chk({tag, "_err"}, {31'b0, c.resp_err}, 32'd0);
    end
    chk({tag, "_wrpulses"}, wr_pulses, exp_wr);
    if (exp_wr != 0) begin
      chk({tag, "_wreg"}, {27'b0, wr_reg_s}, {27'b0, exp_wreg});
      chk({tag, "_rr1"}, {27'b0, rr1_s}, {27'b0, exp_wreg ^ 5'd1});
      chk({tag, "_rr2"}, {27'b0, rr2_s}, {27'b0, exp_wreg ^ 5'd1});
      chk({tag, "_wdata"}, wr_data_s, e.d);
    end
    for (int i = 0; i < stall; i++) begin
      c.req_valid = 1'b1;
      c.req_op    = OP_LDI;
      c.req_rd    = 5'd9;
      c.req_imm   = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, {31'b0, c.resp_valid}, 32'd1);
      chk({tag, "_stall_data"}, c.resp_data, e.d);
      chk({tag, "_stall_rdy"}, {31'b0, c.req_ready}, 32'd0);
    end
    c.req_valid  = 1'b0;
    if (stall != 0)
      chk({tag, "_stall_wr"}, wr_pulses, exp_wr);
    c.resp_ready = 1'b1;
    @(posedge clk); #1;
    c.resp_ready = 1'b0;
    chk({tag, "_hs_valid"}, {31'b0, c.resp_valid}, 32'd0);
    chk({tag, "_hs_ready"}, {31'b0, c.req_ready}, 32'd1);
  endtask

  task automatic run(input string tag,
                     input logic [2:0] op,
                     input logic [4:0] rd,
                     input logic [4:0] rs1,
                     input logic [4:0] rs2,
                     input logic [31:0] imm,
                     input logic [31:0] ed,
                     input logic ez,
                     input logic eo,
                     input int stall);
    sb.push_back('{d: ed, z: ez, o: eo});
    send(op, rd, rs1, rs2, imm);
    recv(tag, (op == OP_RD) ? 0 : 1, rd, stall);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, {31'b0, c.req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'b0, c.resp_valid}, 32'd0);
    chk({tag, "_resp_data"}, c.resp_data, 32'd0);
    chk({tag, "_resp_flags"},
        {29'b0, c.resp_zero, c.resp_ovf, c.resp_err}, 32'd0);
    chk({tag, "_rf_write"}, {31'b0, r.rf_write}, 32'd0);
    chk({tag, "_rf_addrs"},
        {17'b0, r.rf_read_reg1, r.rf_read_reg2, r.rf_write_reg},
        32'd0);
    chk({tag, "_rf_wdata"}, r.rf_write_data, 32'd0);
  endtask

  initial begin
    c.req_valid  = 1'b0;
    c.req_op     = '0;
    c.req_rd     = '0;
    c.req_rs1    = '0;
    c.req_rs2    = '0;
    c.req_imm    = '0;
    c.resp_ready = 1'b0;

    #12;
    chk_reset("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("ldi_r3", OP_LDI, 5'd3, 5'd0, 5'd0, 32'd5,
        32'd5, 1'b0, 1'b0, 0);
    run("ldi_r4", OP_LDI, 5'd4, 5'd0, 5'd0, 32'h7FFF_FFFF,
        32'h7FFF_FFFF, 1'b0, 1'b0, 0);
    run("add_r5", OP_ADD, 5'd5, 5'd4, 5'd3, 32'd0,
        32'h8000_0004, 1'b0, 1'b1, 0);
    run("rd_r5", OP_RD, 5'd0, 5'd5, 5'd0, 32'd0,
        32'h8000_0004, 1'b0, 1'b0, 0);
    run("sub_r3", OP_SUB, 5'd3, 5'd3, 5'd3, 32'd0,
        32'd0, 1'b1, 1'b0, 0);
    run("rd_r3", OP_RD, 5'd0, 5'd3, 5'd0, 32'd0,
        32'd0, 1'b1, 1'b0, 0);
    run("ldi_r1", OP_LDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run("ldi_r2", OP_LDI, 5'd2, 5'd0, 5'd0, 32'd1,
        32'd1, 1'b0, 1'b0, 0);
    run("slt_r6", OP_SLT, 5'd6, 5'd1, 5'd2, 32'd0,
        32'd1, 1'b0, 1'b0, 0);
    run("xor_r8", OP_XOR, 5'd8, 5'd1, 5'd1, 32'd0,
        32'd0, 1'b1, 1'b0, 0);
    run("and_r10", OP_AND, 5'd10, 5'd4, 5'd1, 32'd0,
        32'h7FFF_FFFF, 1'b0, 1'b0, 0);
    run("or_r11", OP_OR, 5'd11, 5'd5, 5'd2, 32'd0,
        32'h8000_0005, 1'b0, 1'b0, 0);
    run("rd_stall", OP_RD, 5'd0, 5'd4, 5'd0, 32'd0,
        32'h7FFF_FFFF, 1'b0, 1'b0, 10);
    run("rd_r9", OP_RD, 5'd0, 5'd9, 5'd0, 32'd0,
        32'd0, 1'b1, 1'b0, 0);

    run("ldi_r7", OP_LDI, 5'd7, 5'd0, 5'd0, 32'h0000_1234,
        32'h0000_1234, 1'b0, 1'b0, 0);
    send(OP_ADD, 5'd7, 5'd4, 5'd4, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_exec");
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst_hold");
    chk("rst_no_write", wr_pulses, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("rd_r7", OP_RD, 5'd0, 5'd7, 5'd0, 32'd0,
        32'h0000_1234, 1'b0, 1'b0, 0);

    chk("dropped_writes", drops, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Initiator side of the register-file port: accepts calculator operation requests, issues reads, waits out the register file's one-cycle registered read latency, computes a result, and writes it back.
- Guarantees every write it issues is actually committed. The register file silently drops a write whose `writeReg` equals either read address in the same cycle; this block prevents that case.
- Sits between the calculator FSM (request/response side) and `regfile` (`rf_*` side).

Parameters:
- `DATA_W`, 32, data width; must match the register file.
- `ADDR_W`, 5, register address width (32 registers).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `req_op`  in  3  operation code.
- `req_rd`  in  ADDR_W  destination register.
- `req_rs1`  in  ADDR_W  source register 1.
- `req_rs2`  in  ADDR_W  source register 2.
- `req_imm`  in  DATA_W  immediate operand for LDI.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_data`  out  DATA_W  computed result, or read value for RD.
- `resp_zero`  out  1  `resp_data` equals 0.
- `resp_ovf`  out  1  signed overflow (ADD/SUB only).
- `resp_err`  out  1  illegal opcode.
- `rf_read_reg1`  out  ADDR_W  drives `readReg1`.
- `rf_read_reg2`  out  ADDR_W  drives `readReg2`.
- `rf_read_data1`  in  DATA_W  from `readData1`.
- `rf_read_data2`  in  DATA_W  from `readData2`.
- `rf_write_reg`  out  ADDR_W  drives `writeReg`.
- `rf_write_data`  out  DATA_W  drives `writeData`.
- `rf_write`  out  1  drives `write`.

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst_n` is asynchronous and active-low.
  - All outputs are registered.
  - Reset value of every output is 0, except `req_ready`, which is 1.
- Opcodes (3 bits):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0 or 1).
  - 6 LDI (write `req_imm`, no reads used).
  - 7 RD (read `rs1` only; `resp_data` = value; no write).
- FSM states: IDLE, READ, EXEC, WRITE, RESP.
  - IDLE: `req_ready`=1. On `req_valid`&&`req_ready`:
    - latch op, rd, rs1, rs2, imm;
    - set `rf_read_reg1`<=rs1, `rf_read_reg2`<=rs2;
    - go to READ.
  - READ: the register file samples the addresses on this edge. Go to EXEC.
  - EXEC: `rf_read_data1`/`rf_read_data2` are valid.
    - Compute the result with DATA_W wraparound arithmetic.
    - Register it into `resp_data`, `resp_zero`, and `resp_ovf`.
    - `resp_ovf` = sign(a)==sign(±b) && sign(result)!=sign(a); it is 0 for all non-ADD/SUB ops.
    - For ops 0–6: `rf_write_reg`<=rd, `rf_write_data`<=result, `rf_write`<=1.
    - Steer both read addresses to rd^1 in the same edge. This guarantees neither equals rd, so the write is never suppressed.
    - For RD: `rf_write`<=0.
    - Go to WRITE.
  - WRITE: the write commits on this edge. Set `rf_write`<=0 and `resp_valid`<=1. Go to RESP.
  - RESP: hold `resp_valid` and all `resp_*` stable until `resp_ready`. On the handshake: `resp_valid`<=0, `req_ready`<=1, go to IDLE.
- Latency: request accepted at edge N; `rf_write` is high during cycle N+2 to N+3; `resp_valid` is first high after edge N+3.
  - If `resp_ready` is held high, a new request can be accepted at edge N+5 at the earliest.
- `rf_write` is high for exactly one cycle per writing op and is never high outside WRITE.
- rs1==rs2 and rd==rs1 are legal:
  - reads complete in READ, before the write;
  - the result uses the old values;
  - the written value is the new one.
- Back-to-back dependency (op B reads op A's rd) sees A's written value, because B's READ occurs after A's WRITE edge.
- Illegal opcodes: the 3-bit space is fully decoded, so `resp_err` is reserved and tied 0.
  - An X/undefined op value goes through the default branch: no write, `resp_err`=1.
- Reset mid-operation (any state):
  - immediately forces IDLE;
  - `rf_write`=0, so no partial write;
  - `resp_valid`=0;
  - the pending request is discarded.
- `req_*` inputs are ignored outside IDLE.

Decomposition:
- Shared package `calc_pkg`: opcode constants (OP_ADD..OP_RD), FSM state encoding, DATA_W/ADDR_W defaults.
- One natural sub-module: `calc_alu` (combinational op/a/b/imm -> result, zero, ovf). It is reused by the EXEC state and available to the calculator top.

Test Plan:
- Reset, then LDI rd=3 imm=0x0000_0005 -> `rf_write` pulse exactly one cycle with `rf_write_reg`=3; `rf_read_reg1`/`rf_read_reg2`=2 during that cycle; `resp_data`=5, `resp_zero`=0.
- With r3=5: LDI r4=0x7FFF_FFFF, then ADD rd=5 rs1=4 rs2=3 -> `resp_data`=0x8000_0004, `resp_ovf`=1; RD rs1=5 returns 0x8000_0004.
- SUB rd=3 rs1=3 rs2=3 (r3=5) -> `resp_data`=0, `resp_zero`=1; subsequent RD r3 returns 0, proving the self-overwriting write committed.
- SLT with r1=0xFFFF_FFFF, r2=1 -> `resp_data`=1. XOR r1,r1 -> 0.
- Hold `resp_ready`=0 for 10 cycles -> `resp_valid` and `resp_data` stay stable, `req_ready`=0, new `req_valid` ignored; release -> handshake, `req_ready`=1 next cycle.
- Assert `rst_n`=0 during EXEC of ADD rd=7 -> `rf_write` never pulses; RD r7 after reset returns the prior value; all outputs at reset values while reset is held.
